// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate/pixel types and colour constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_timing_pkg;

    // 640x480@60 timing, 25 MHz pixel clock
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    // First active column / row in counter space
    localparam int HA = H_SYNC + H_BACK;
    localparam int VA = V_SYNC + V_BACK;

    localparam int COORD_W = 10;

    // RGB565 layout
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int RGB_W = R_W + G_W + B_W;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Colours shared by the pixel generators
    localparam rgb_t COL_BLACK = 16'h0000;
    localparam rgb_t COL_WHITE = 16'hFFFF;
    localparam rgb_t COL_RED   = 16'hF800;
    localparam rgb_t COL_GREEN = 16'h07E0;
    localparam rgb_t COL_BLUE  = 16'h001F;

    function automatic rgb_t rgb565(input logic [R_W-1:0] r,
                                    input logic [G_W-1:0] g,
                                    input logic [B_W-1:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_ctrl_if.sv
// Pixel request/response bundle between vga_ctrl and the upstream pixel generator.
// Latency: pix_data answers the coordinate issued one cycle earlier.
// Backpressure: none; every pix_req must be answered.
// Signals: pix_req/pix_x/pix_y (request, from vga_ctrl), pix_data (response, to vga_ctrl).
interface vga_ctrl_if #(
    parameter int RGB_W = vga_timing_pkg::RGB_W
);
    import vga_timing_pkg::*;

    logic             pix_req;
    coord_t           pix_x;
    coord_t           pix_y;
    logic [RGB_W-1:0] pix_data;

    // master = timing controller, slave = pixel generator
    modport master (output pix_req, output pix_x, output pix_y, input  pix_data);
    modport slave  (input  pix_req, input  pix_x, input  pix_y, output pix_data);

endinterface

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical scan counters with active and one-pixel-lookahead window flags.
// Latency: counters registered; window flags combinational from counter state.
// Backpressure: none; free-running every clock.
// Ports: clk, rst_n (async, active low), cnt_h/cnt_v (scan position), active, req_win.
module vga_timing_cnt #(
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_VALID = vga_timing_pkg::H_VALID,
    parameter int H_FRONT = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BACK  = vga_timing_pkg::V_BACK,
    parameter int V_VALID = vga_timing_pkg::V_VALID,
    parameter int V_FRONT = vga_timing_pkg::V_FRONT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [vga_timing_pkg::COORD_W-1:0] cnt_h,
    output logic [vga_timing_pkg::COORD_W-1:0] cnt_v,
    output logic                              active,
    output logic                              req_win
);
    import vga_timing_pkg::*;

    localparam int H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT = H_SYNC + H_BACK;
    localparam int V_ACT = V_SYNC + V_BACK;

    localparam coord_t H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT_LO  = coord_t'(H_ACT);
    localparam coord_t H_ACT_HI  = coord_t'(H_ACT + H_VALID);
    localparam coord_t H_REQ_LO  = coord_t'(H_ACT - 1);
    localparam coord_t H_REQ_HI  = coord_t'(H_ACT + H_VALID - 1);
    localparam coord_t V_ACT_LO  = coord_t'(V_ACT);
    localparam coord_t V_ACT_HI  = coord_t'(V_ACT + V_VALID);

    // Totals must fit the 10-bit counters
    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
            $error("vga_timing_cnt: H/V totals exceed 10-bit counter range");
        end
    endgenerate

    logic h_act;
    logic h_req;
    logic v_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            // line wrap and row advance on the same edge, no idle cycle
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    always_comb begin
        h_act   = (cnt_h >= H_ACT_LO) && (cnt_h < H_ACT_HI);
        // request window leads the active window by one column and ends one
        // column early, so the lookahead never spills into the next line
        h_req   = (cnt_h >= H_REQ_LO) && (cnt_h < H_REQ_HI);
        v_act   = (cnt_v >= V_ACT_LO) && (cnt_v < V_ACT_HI);
        active  = h_act && v_act;
        req_win = h_req && v_act;
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator: lookahead pixel request plus registered sync/rgb pins.
// Latency: pins lag counter state by one cycle; pix_data sampled one cycle after its request.
// Backpressure: none; upstream must answer every pix_req on the following cycle.
// Ports: vga_clk, sys_rst_n, pix (request bus), hsync, vsync, rgb, rgb_valid, frame_start.
module vga_ctrl #(
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK   = vga_timing_pkg::H_BACK,
    parameter int   H_VALID  = vga_timing_pkg::H_VALID,
    parameter int   H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK   = vga_timing_pkg::V_BACK,
    parameter int   V_VALID  = vga_timing_pkg::V_VALID,
    parameter int   V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int   RGB_W    = vga_timing_pkg::RGB_W,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    vga_ctrl_if.master       pix,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             rgb_valid,
    output logic             frame_start
);
    import vga_timing_pkg::*;

    localparam coord_t H_REQ_OFS  = coord_t'(H_SYNC + H_BACK - 1);
    localparam coord_t V_ACT_OFS  = coord_t'(V_SYNC + V_BACK);
    localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_END = coord_t'(V_SYNC);

    coord_t cnt_h;
    coord_t cnt_v;
    logic   active;
    logic   req_win;

    vga_timing_cnt #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_VALID (H_VALID),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_VALID (V_VALID),
        .V_FRONT (V_FRONT)
    ) u_cnt (
        .clk     (vga_clk),
        .rst_n   (sys_rst_n),
        .cnt_h   (cnt_h),
        .cnt_v   (cnt_v),
        .active  (active),
        .req_win (req_win)
    );

    // Coordinates are forced to 0 outside the request window so the
    // upstream never sees out-of-range values.
    always_comb begin
        pix.pix_req = req_win;
        pix.pix_x   = '0;
        pix.pix_y   = '0;
        if (req_win) begin
            pix.pix_x = cnt_h - H_REQ_OFS;
            pix.pix_y = cnt_v - V_ACT_OFS;
        end
    end

    // Single output stage; every pin is registered from the same counter
    // state so they stay mutually aligned.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb         <= '0;
            rgb_valid   <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            rgb         <= active ? pix.pix_data : '0;
            rgb_valid   <= active;
            hsync       <= (cnt_h < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (cnt_v < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            frame_start <= (cnt_h == '0) && (cnt_v == '0);
        end
    end

endmodule
